// File: rtl/my_pipelined_adder.sv
// my_pipelined_adder
//   Carry-chained pipelined adder/subtractor. The operands are split into
//   STAGES chunks of CH = WIDTH/STAGES bits. Stage k adds chunk k plus the
//   carry from stage k-1, appends the partial sum to the result bits already
//   formed, and forwards only the operand bits that are still pending.
//   Subtraction is A + ~B + 1. A single advance signal moves or holds the
//   whole pipeline, so back-pressure on the output freezes every stage.
//
// Parameters
//   WIDTH  : operand/sum width, 8..64
//   STAGES : pipeline depth; WIDTH must be a multiple of STAGES
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand set presented
//   in_ready   out  operand set accepted this cycle (= advance)
//   a, b       in   operands
//   sub        in   0: a+b+cin, 1: a-b
//   cin        in   carry-in, ignored when sub=1
//   out_valid  out  result presented
//   out_ready  in   consumer accepts the result
//   sum        out  result
//   cout       out  carry out of the MSB (for sub: 1 = no borrow)
//   ovf        out  two's-complement overflow, present only when the macro
//                   MY_PIPELINED_ADDER_OVF_EN is defined
module my_pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef MY_PIPELINED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CH = WIDTH / STAGES;

  logic             adv_s;
  logic [WIDTH-1:0] b_eff_s;
  logic             c_eff_s;

  // Operand conditioning: subtraction becomes A + ~B + 1.
  always_comb begin
    b_eff_s = b;
    c_eff_s = cin;
    if (sub) begin
      b_eff_s = ~b;
      c_eff_s = 1'b1;
    end else begin
      b_eff_s = b;
      c_eff_s = cin;
    end
  end

  // The whole pipeline moves whenever the output slot is empty or being drained.
  assign adv_s    = ~out_valid | out_ready;
  assign in_ready = adv_s;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    // Operand bits entering this stage that have not been added yet.
    localparam int PEND = WIDTH - k * CH;

    logic [PEND-1:0]       a_in_s;
    logic [PEND-1:0]       b_in_s;
    logic                  c_in_s;
    logic                  v_in_s;
    logic [CH:0]           add_s;
    logic                  vld_r;
    logic                  carry_r;
    logic [(k+1)*CH-1:0]   sum_r;

    if (k == 0) begin : g_src
      assign a_in_s = a;
      assign b_in_s = b_eff_s;
      assign c_in_s = c_eff_s;
      assign v_in_s = in_valid;
    end else begin : g_src
      assign a_in_s = stg[k-1].g_rem.a_rem_r;
      assign b_in_s = stg[k-1].g_rem.b_rem_r;
      assign c_in_s = stg[k-1].carry_r;
      assign v_in_s = stg[k-1].vld_r;
    end

    assign add_s = {1'b0, a_in_s[CH-1:0]} + {1'b0, b_in_s[CH-1:0]} + {{CH{1'b0}}, c_in_s};

    // Stage valid bit and chunk carry.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_r   <= 1'b0;
        carry_r <= 1'b0;
      end else if (adv_s) begin
        vld_r   <= v_in_s;
        carry_r <= add_s[CH];
      end
    end

    if (k == 0) begin : g_sum
      // First chunk of the result.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_r <= '0;
        end else if (adv_s) begin
          sum_r <= add_s[CH-1:0];
        end
      end
    end else begin : g_sum
      // New chunk is placed above the bits formed by earlier stages.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_r <= '0;
        end else if (adv_s) begin
          sum_r <= {add_s[CH-1:0], stg[k-1].sum_r};
        end
      end
    end

    if (k < STAGES - 1) begin : g_rem
      logic [PEND-CH-1:0] a_rem_r;
      logic [PEND-CH-1:0] b_rem_r;

      // Operand skew: forward only the chunks later stages still need.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_rem_r <= '0;
          b_rem_r <= '0;
        end else if (adv_s) begin
          a_rem_r <= a_in_s[PEND-1:CH];
          b_rem_r <= b_in_s[PEND-1:CH];
        end
      end
    end

`ifdef MY_PIPELINED_ADDER_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_r;

      // The sign bits of a and b_eff arrive as the top bits of the skewed
      // operands, so the last stage sees them without extra sign registers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_r <= 1'b0;
        end else if (adv_s) begin
          ovf_r <= (a_in_s[CH-1] == b_in_s[CH-1]) && (add_s[CH-1] != a_in_s[CH-1]);
        end
      end
    end
`endif
  end

  assign out_valid = stg[STAGES-1].vld_r;
  assign sum       = stg[STAGES-1].sum_r;
  assign cout      = stg[STAGES-1].carry_r;
`ifdef MY_PIPELINED_ADDER_OVF_EN
  assign ovf       = stg[STAGES-1].g_ovf.ovf_r;
`endif

endmodule

// File: doc/my_pipelined_adder.md
MY_PIPELINED_ADDER -- requirements
Module: my_pipelined_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the operand and sum width in bits; legal values are 8 to 64.
REQ-002 The block SHALL have parameter STAGES, default 4, meaning the pipeline depth; WIDTH SHALL be divisible by STAGES, and each stage adds one CH = WIDTH/STAGES bit chunk.
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an operand set is presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the operand set this cycle.
REQ-007 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-008 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-009 The block SHALL have port sub, input, 1 bit: 0 selects A+B+cin, 1 selects A-B.
REQ-010 The block SHALL have port cin, input, 1 bit: carry-in, used only when sub=0.
REQ-011 The block SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 The block SHALL have port sum, output, WIDTH bits: the result.
REQ-014 The block SHALL have port cout, output, 1 bit: carry out of the MSB.
REQ-015 The block SHALL have port ovf, output, 1 bit: two's-complement overflow; this port SHALL be present only under the macro in REQ-027.

Function
REQ-016 The block SHALL compute the effective operand as b_eff = sub ? ~b : b and the effective carry-in as c_eff = sub ? 1 : cin.
REQ-017 Stage k (k = 0..STAGES-1) SHALL add chunk k of a and b_eff plus the carry registered by stage k-1 (c_eff for k=0), register the CH-bit partial sum and the carry, and forward the not-yet-added upper chunks unchanged (operand skew).
REQ-018 The block SHALL use a global advance signal, adv = !out_valid || out_ready; when adv=1 every stage register and valid bit SHALL shift one stage, and when adv=0 all pipeline state SHALL hold.
REQ-019 The block SHALL drive in_ready = adv combinationally; a transfer SHALL occur when in_valid && in_ready, and valid-0 bubbles SHALL propagate when in_valid=0.
REQ-020 Latency SHALL be exactly STAGES cycles from the accepting edge to out_valid=1 with no stall; throughput SHALL be one result per cycle while out_ready=1.
REQ-021 The block SHALL hold sum, cout, ovf and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 The block SHALL present results in acceptance order; no transaction SHALL be dropped or duplicated under any in_valid/out_ready pattern.
REQ-023 The block SHALL use the following boundary values: cout = bit WIDTH of the full sum; for sub=1, cout=1 means no borrow (a >= b unsigned). With STAGES=1, the block SHALL behave as a single registered adder.

Reset
REQ-024 The block SHALL clear all valid bits, out_valid, sum, cout, ovf and every stage register to 0 on rst_n=0, with no clock required.
REQ-025 In-flight transactions SHALL be discarded on reset assertion mid-operation; in_ready SHALL read 1 during and after reset, because out_valid=0.
REQ-026 The block SHALL treat reset deassertion as synchronous-safe, taking first acceptance at the first rising clk edge with rst_n=1.

Configuration
REQ-027 With macro MY_PIPELINED_ADDER_OVF_EN defined, the block SHALL include the ovf port and pipe the sign bits of a and b_eff to the last stage, with ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb).
REQ-028 With MY_PIPELINED_ADDER_OVF_EN undefined, the block SHALL omit the ovf port and its sign-bit registers; all other behaviour SHALL be identical.

Verification
REQ-029 The bench SHALL cover this scenario with WIDTH=32, STAGES=4: a=0xFFFFFFFF, b=1, cin=0, sub=0, out_ready=1 -> out_valid rises 4 cycles later with sum=0, cout=1, ovf=0.
REQ-030 The bench SHALL cover this scenario: a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, cout=0, ovf=1 (macro on); the ovf port is absent when the macro is off.
REQ-031 The bench SHALL cover this scenario: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0; then a=7, b=5, sub=1 -> sum=2, cout=1.
REQ-032 The bench SHALL cover this scenario: 10 back-to-back random operand sets with out_ready held 0 for cycles 6..9 -> in_ready=0 in those cycles, outputs held, and all 10 results correct and in order.
REQ-033 The bench SHALL cover this scenario: rst_n pulsed low for 1 ns while 3 transactions are in flight -> out_valid=0 immediately, no stale result ever emitted, and the next accepted operand yields a correct result after 4 cycles.
REQ-034 The bench SHALL cover this scenario for parameter sweep WIDTH/STAGES = 8/1, 16/2, 64/8: 1000 random operand sets with random out_ready -> results match a+b_eff+c_eff mod 2^WIDTH with correct cout.
